// File: rtl/mmx_writeback_pkg.sv
// Shared types and widths for the MMX writeback buffer.
package mmx_writeback_pkg;

  localparam int MMX_REG_W  = 3;
  localparam int MMX_DATA_W = 64;

  typedef struct packed {
    logic [MMX_REG_W-1:0]  dest;
    logic [MMX_DATA_W-1:0] data;
  } mmx_wb_entry_t;

endpackage

// File: rtl/mmx_writeback_fifo.sv
// In-order storage for mmx_writeback: pointers, occupancy and entry arrays.
// The flattened entry views let the top level search every slot for bypass.
module mmx_wb_fifo
  import mmx_writeback_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = MMX_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [MMX_REG_W-1:0]          push_dest,
  input  logic [DATA_W-1:0]             push_data,
  output logic [MMX_REG_W-1:0]          head_dest,
  output logic [DATA_W-1:0]             head_data,
  output logic                          full,
  output logic                          empty,
  output logic [CNT_W-1:0]              count,
  output logic [PTR_W-1:0]              rd_ptr,
  output logic [DEPTH*MMX_REG_W-1:0]    mem_dest_flat,
  output logic [DEPTH*DATA_W-1:0]       mem_data_flat
);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [MMX_REG_W-1:0] mem_dest_q [DEPTH];
  logic [MMX_REG_W-1:0] mem_dest_d [DEPTH];
  logic [DATA_W-1:0]    mem_data_q [DEPTH];
  logic [DATA_W-1:0]    mem_data_d [DEPTH];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_dest_d = mem_dest_q;
    mem_data_d = mem_data_q;
    if (push) begin
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      mem_dest_d[wr_ptr_q] = push_dest;
      mem_data_d[wr_ptr_q] = push_data;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head of an empty buffer reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dest_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_dest_q <= mem_dest_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    mem_dest_flat = '0;
    mem_data_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_dest_flat[i*MMX_REG_W +: MMX_REG_W] = mem_dest_q[i];
      mem_data_flat[i*DATA_W +: DATA_W]       = mem_data_q[i];
    end
  end

  assign head_dest = mem_dest_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign count     = count_q;
  assign rd_ptr    = rd_ptr_q;

endmodule

// File: rtl/mmx_writeback.sv
// MMX writeback buffer: accepts execute results, retires one per cycle to the RF.
// Define MMX_WB_BYPASS_EN to enable the lookup_* bypass search of queued results.
module mmx_writeback
  import mmx_writeback_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = MMX_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_wr,
  input  logic [MMX_REG_W-1:0]   in_dest,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   rf_ready,
  output logic                   write_enable,
  output logic [MMX_REG_W-1:0]   write_select,
  output logic [DATA_W-1:0]      write_data,
  output logic [$clog2(DEPTH):0] count,
  input  logic [MMX_REG_W-1:0]   lookup_reg,
  output logic                   lookup_hit,
  output logic [DATA_W-1:0]      lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [PTR_W-1:0]           rd_ptr;
  logic [DEPTH*MMX_REG_W-1:0] mem_dest_flat;
  logic [DEPTH*DATA_W-1:0]    mem_data_flat;

  // in_ready depends only on stored occupancy, so a same-cycle pop never frees a full slot.
  assign in_ready     = ~full;
  assign push         = in_valid & in_ready & in_wr;
  assign write_enable = ~empty & rf_ready;
  assign pop          = write_enable;

  mmx_wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk           (clk),
    .rst           (reset),
    .push          (push),
    .pop           (pop),
    .push_dest     (in_dest),
    .push_data     (in_data),
    .head_dest     (write_select),
    .head_data     (write_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .rd_ptr        (rd_ptr),
    .mem_dest_flat (mem_dest_flat),
    .mem_data_flat (mem_data_flat)
  );

`ifdef MMX_WB_BYPASS_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) &&
          (mem_dest_flat[int'(idx)*MMX_REG_W +: MMX_REG_W] == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_data_flat[int'(idx)*DATA_W +: DATA_W];
      end else begin
        lookup_hit  = lookup_hit;
        lookup_data = lookup_data;
      end
    end
  end
`else
  logic unused_bypass;

  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
  assign unused_bypass = ^{lookup_reg, rd_ptr, mem_dest_flat, mem_data_flat};
`endif

endmodule

// File: tb/tb_mmx_writeback.sv
// Scoreboard bench for mmx_writeback: directed offers queue expected retirements,
// a negedge monitor checks every write_enable against the queue.
module tb_mmx_writeback;
  import mmx_writeback_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wr;
  logic [MMX_REG_W-1:0]  in_dest;
  logic [MMX_DATA_W-1:0] in_data;
  logic                  rf_ready;
  logic                  write_enable;
  logic [MMX_REG_W-1:0]  write_select;
  logic [MMX_DATA_W-1:0] write_data;
  logic [2:0]            count;
  logic [MMX_REG_W-1:0]  lookup_reg;
  logic                  lookup_hit;
  logic [MMX_DATA_W-1:0] lookup_data;

  int passed = 0;
  int total  = 0;
  mmx_wb_entry_t exp_q[$];

  mmx_writeback #(.DEPTH(4), .DATA_W(MMX_DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wr        (in_wr),
    .in_dest      (in_dest),
    .in_data      (in_data),
    .rf_ready     (rf_ready),
    .write_enable (write_enable),
    .write_select (write_select),
    .write_data   (write_data),
    .count        (count),
    .lookup_reg   (lookup_reg),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Monitor: every retirement must match the oldest expected entry.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_retire: got sel=%0d data=%h expected no retire at %0t",
                 write_select, write_data, $time);
      end else begin
        mmx_wb_entry_t e;
        e = exp_q.pop_front();
        check("retire_sel", 64'(write_select), 64'(e.dest));
        check("retire_data", write_data, e.data);
      end
    end
  end

  // Present one result for a cycle; exp_acc is the bench's own acceptance prediction.
  task automatic offer(input logic [2:0] d, input logic [63:0] v, input logic wr, input logic exp_acc);
    mmx_wb_entry_t e;
    in_valid = 1'b1; in_wr = wr; in_dest = d; in_data = v;
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(exp_acc));
    if (exp_acc && wr) begin
      e.dest = d; e.data = v;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_wr = 1'b0;
  endtask

  task automatic drain();
    rf_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_done", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_wr = 1'b0; in_dest = 3'd0; in_data = 64'd0;
    rf_ready = 1'b1; lookup_reg = 3'd0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_sel", 64'(write_select), 64'd0);
    check("rst_data", write_data, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_hit", 64'(lookup_hit), 64'd0);
    check("rst_ldata", lookup_data, 64'd0);
    @(posedge clk); #1; reset = 1'b0;

    // single push retires next cycle
    offer(3'd3, 64'h1122334455667788, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_we", 64'(write_enable), 64'd1);
    check("lat_count", 64'(count), 64'd1);
    @(negedge clk);
    check("lat_count_after", 64'(count), 64'd0);
    check("lat_we_after", 64'(write_enable), 64'd0);
    @(posedge clk); #1;

    // fill with rf stalled, reject fifth, then drain in order
    rf_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(3'(i), 64'hA000 + 64'(i), 1'b1, 1'b1);
    offer(3'd4, 64'hDEAD, 1'b1, 1'b0);
    @(negedge clk);
    check("full_count", 64'(count), 64'd4);
    @(posedge clk); #1;
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_we", 64'(write_enable), 64'd1);
      check("drain_cnt", 64'(count), 64'(4 - i));
    end
    @(negedge clk);
    check("drained_we", 64'(write_enable), 64'd0);
    @(posedge clk); #1;

    // full with simultaneous pop: push refused, accepted next cycle
    rf_ready = 1'b0;
    for (int i = 4; i < 8; i++) offer(3'(i), 64'hB000 + 64'(i), 1'b1, 1'b1);
    rf_ready = 1'b1;
    offer(3'd1, 64'hC0FFEE, 1'b1, 1'b0);
    rf_ready = 1'b0;
    @(negedge clk);
    check("pop_full_count", 64'(count), 64'd3);
    @(posedge clk); #1;
    offer(3'd1, 64'hC0FFEE, 1'b1, 1'b1);
    @(negedge clk);
    check("refill_count", 64'(count), 64'd4);
    @(posedge clk); #1;
    drain();

    // consumed-only result stores nothing
    offer(3'd2, 64'h5555, 1'b0, 1'b1);
    @(negedge clk);
    check("nowr_count", 64'(count), 64'd0);
    check("nowr_we", 64'(write_enable), 64'd0);
    @(posedge clk); #1;

    // bypass: youngest match, in-flight push excluded
    rf_ready = 1'b0;
    offer(3'd5, 64'hAAAA, 1'b1, 1'b1);
    offer(3'd5, 64'hBBBB, 1'b1, 1'b1);
    lookup_reg = 3'd5;
    in_valid = 1'b1; in_wr = 1'b1; in_dest = 3'd5; in_data = 64'hCCCC;
    @(negedge clk);
`ifdef MMX_WB_BYPASS_EN
    check("byp_hit", 64'(lookup_hit), 64'd1);
    check("byp_data", lookup_data, 64'hBBBB);
`else
    check("nobyp_hit", 64'(lookup_hit), 64'd0);
    check("nobyp_data", lookup_data, 64'd0);
`endif
    exp_q.push_back('{dest: 3'd5, data: 64'hCCCC});
    @(posedge clk); #1;
    in_valid = 1'b0; in_wr = 1'b0;
    @(negedge clk);
`ifdef MMX_WB_BYPASS_EN
    check("byp_young", lookup_data, 64'hCCCC);
`else
    check("nobyp_young", 64'(lookup_hit), 64'd0);
`endif
    lookup_reg = 3'd6;
    #1;
    check("byp_miss", 64'(lookup_hit), 64'd0);
    @(posedge clk); #1;
    drain();

    // reset with queued entries drops them immediately
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(3'(i + 1), 64'hE000 + 64'(i), 1'b1, 1'b1);
    @(negedge clk);
    check("pre_rst_count", 64'(count), 64'd3);
    #1;
    reset = 1'b1; rf_ready = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_we", 64'(write_enable), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_count", 64'(count), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
